// File: rtl/mmio_pkg.sv
// Shared constants for the MMIO port responder: register offsets, STATUS bit
// positions and a helper that packs the STATUS word.
package mmio_pkg;

    localparam logic [1:0] OFF_OUT_DATA = 2'd0;
    localparam logic [1:0] OFF_STATUS   = 2'd1;
    localparam logic [1:0] OFF_IN_DATA  = 2'd2;
    localparam logic [1:0] OFF_CYCLES   = 2'd3;

    localparam int ST_FULL      = 0;
    localparam int ST_EMPTY     = 1;
    localparam int ST_OVF       = 2;
    localparam int ST_LEVEL_LSB = 8;

    function automatic logic [31:0] status_word(input logic       full,
                                                input logic       empty,
                                                input logic       ovf,
                                                input logic [7:0] level);
        logic [31:0] w;
        w                      = '0;
        w[ST_FULL]             = full;
        w[ST_EMPTY]            = empty;
        w[ST_OVF]              = ovf;
        w[ST_LEVEL_LSB +: 8]   = level;
        return w;
    endfunction

endpackage

// File: rtl/mmio_port_responder_if.sv
// Data-memory bus plus output byte stream seen by the MMIO port responder.
// The responder uses the slave modport; the core/consumer side uses master.
interface mmio_port_responder_if;
    logic        Mem_Write_i;
    logic        Mem_Read_i;
    logic [31:0] Address_i;
    logic [31:0] Write_Data_i;
    logic [31:0] Read_Data_o;
    logic        Hit_o;
    logic [7:0]  Out_Data_o;
    logic        Out_Valid_o;
    logic        Out_Ready_i;

    modport slave (
        input  Mem_Write_i, Mem_Read_i, Address_i, Write_Data_i, Out_Ready_i,
        output Read_Data_o, Hit_o, Out_Data_o, Out_Valid_o
    );

    modport master (
        output Mem_Write_i, Mem_Read_i, Address_i, Write_Data_i, Out_Ready_i,
        input  Read_Data_o, Hit_o, Out_Data_o, Out_Valid_o
    );
endinterface

// File: rtl/mmio_sync_fifo.sv
// Single-clock FIFO with occupancy count. Pushes while full and pops while
// empty are ignored; the head reads as zero whenever the FIFO is empty.
module mmio_sync_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 8,
    localparam int AW    = $clog2(DEPTH),
    localparam int LW    = AW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [LW-1:0]    level_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic             do_push, do_pop;

    assign full_o  = (level_q == LW'(DEPTH));
    assign empty_o = (level_q == '0);
    assign level_o = level_q;
    // Full/empty are judged on the pre-edge level, so a push into a full FIFO
    // is dropped even when a pop frees a slot in the same cycle.
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;
    assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({do_push, do_pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/mmio_port_responder.sv
// MMIO responder in a 16-byte window on the data-memory bus: output byte FIFO,
// status, synchronized input port and (with MMIO_CYCLE_COUNTER_EN) a cycle counter.
module mmio_port_responder
    import mmio_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h1001_0000,
    parameter int          FIFO_DEPTH = 8,
    parameter int          IN_WIDTH   = 8
) (
    input  logic                clk,
    input  logic                reset,
    mmio_port_responder_if.slave bus,
    input  logic [IN_WIDTH-1:0] Gpio_In_i
);

    localparam int          LW       = $clog2(FIFO_DEPTH) + 1;
    localparam logic [27:0] BASE_TAG = BASE_ADDR[31:4];

    logic          hit, wr_en;
    logic [1:0]    off;
    logic          push, pop, ovf_clr;
    logic          fifo_full, fifo_empty;
    logic [LW-1:0] fifo_level;
    logic [7:0]    fifo_head;
    logic          ovf_q, ovf_d;
    logic [IN_WIDTH-1:0] sync1_q, sync2_q;
    logic [31:0]   cyc_rd;
    logic [31:0]   rdata;
    logic          unused_bits;

    assign hit     = (bus.Address_i[31:4] == BASE_TAG) & (bus.Mem_Read_i | bus.Mem_Write_i);
    assign off     = bus.Address_i[3:2];
    assign wr_en   = hit & bus.Mem_Write_i;
    assign push    = wr_en & (off == OFF_OUT_DATA);
    assign ovf_clr = wr_en & (off == OFF_STATUS) & bus.Write_Data_i[ST_OVF];
    assign pop     = ~fifo_empty & bus.Out_Ready_i;

    assign unused_bits = ^{bus.Address_i[1:0], bus.Write_Data_i[31:8]};

    mmio_sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (reset),
        .push_i  (push),
        .wdata_i (bus.Write_Data_i[7:0]),
        .pop_i   (pop),
        .rdata_o (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (fifo_level)
    );

    assign bus.Out_Data_o  = fifo_head;
    assign bus.Out_Valid_o = ~fifo_empty;

    // A dropped push in the same cycle as a clear leaves the flag set.
    always_comb begin
        ovf_d = ovf_q;
        if (ovf_clr)           ovf_d = 1'b0;
        if (push && fifo_full) ovf_d = 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ovf_q   <= 1'b0;
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            ovf_q   <= ovf_d;
            sync1_q <= Gpio_In_i;
            sync2_q <= sync1_q;
        end
    end

`ifdef MMIO_CYCLE_COUNTER_EN
    logic [31:0] cyc_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) cyc_q <= '0;
        else        cyc_q <= cyc_q + 32'd1;
    end

    assign cyc_rd = cyc_q;
`else
    assign cyc_rd = '0;
`endif

    always_comb begin
        rdata = '0;
        if (hit) begin
            case (off)
                OFF_STATUS:  rdata = status_word(fifo_full, fifo_empty, ovf_q, 8'(fifo_level));
                OFF_IN_DATA: rdata = 32'(sync2_q);
                OFF_CYCLES:  rdata = cyc_rd;
                default:     rdata = '0;
            endcase
        end
    end

    assign bus.Read_Data_o = rdata;
    assign bus.Hit_o       = hit;

endmodule
